pipeline_stall_ctrl: RTL

Central stall/flush sequencer for the five-stage core. Detects the RAW hazards that the ID-stage operand forwarding cannot resolve, since EX-stage results are never forwarded. Sequences the multi-cycle divider occupancy of EX and applies exception/redirect flushes. Its outputs drive the PC, IF/ID, ID/EX, EX/MEM and MEM/WB pipeline-register enables.

---
 rtl/pipeline_stall_ctrl.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/pipeline_stall_ctrl.sv
// pipeline_stall_ctrl
//
// Central stall/flush sequencer for the five-stage core.
//  - Detects RAW hazards against the EX-stage destination. EX results are
//    never forwarded, so a match holds PC/IF/ID for a cycle.
//  - Sequences divider occupancy of EX for DIV_CYCLES cycles.
//  - Applies exception/redirect flushes combinationally.
//
// Parameters:
//   DIV_CYCLES  cycles EX is occupied by a divide, start through done (2..255)
//   CNT_W       width of the stall-cycle counter
//
// Ports:
//   clk_i, rst_n_i         clock (rising edge), async active-low reset
//   id_re1_i/id_raddr1_i   ID operand-1 read enable / address
//   id_re2_i/id_raddr2_i   ID operand-2 read enable / address
//   ex_we_i/ex_waddr_i     EX write enable / destination register
//   ex_div_start_i         EX divide requests the divider
//   flush_req_i/flush_pc_i exception/redirect pulse and target
//   stall_o[5:0]           hold: bit0 PC, 1 IF, 2 ID, 3 EX, 4 MEM, 5 WB
//   flush_o, new_pc_o      clear pipeline registers / PC to load on flush
//   div_busy_o, div_done_o divider occupied / result valid in EX
//   stall_cnt_o            count of stalled cycles
//
// Build option:
//   PIPE_STALL_CNT_EN  when defined, stall_cnt_o is a saturating count of
//                      cycles with any stall bit set; otherwise it is tied
//                      to zero and no counter flops exist.
//
// FSM states:
//   state        | meaning
//   ST_IDLE      | divider free; ex_div_start_i accepted here only
//   ST_DIV_BUSY  | divider running, EX and upstream held
//   ST_DIV_DONE  | divide result valid in EX, pipeline released

module pipeline_stall_ctrl #(
  parameter int DIV_CYCLES = 32,
  parameter int CNT_W      = 32
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             id_re1_i,
  input  logic [4:0]       id_raddr1_i,
  input  logic             id_re2_i,
  input  logic [4:0]       id_raddr2_i,
  input  logic             ex_we_i,
  input  logic [4:0]       ex_waddr_i,
  input  logic             ex_div_start_i,
  input  logic             flush_req_i,
  input  logic [31:0]      flush_pc_i,
  output logic [5:0]       stall_o,
  output logic             flush_o,
  output logic [31:0]      new_pc_o,
  output logic             div_busy_o,
  output logic             div_done_o,
  output logic [CNT_W-1:0] stall_cnt_o
);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_DIV_BUSY = 2'd1,
    ST_DIV_DONE = 2'd2
  } state_t;

  // The start cycle and the done cycle are not spent in DIV_BUSY, so the
  // busy state lasts DIV_CYCLES-2 cycles.
  localparam logic [7:0] DIV_LOAD = 8'(DIV_CYCLES - 2);

  localparam logic [5:0] STALL_DIV    = 6'b001111;
  localparam logic [5:0] STALL_HAZARD = 6'b000111;

  state_t     state_q, state_d;
  logic [7:0] div_cnt_q, div_cnt_d;

  logic hazard;
  logic div_accept;

  assign hazard = (id_re1_i & ex_we_i & (id_raddr1_i == ex_waddr_i) & (id_raddr1_i != 5'd0)) |
                  (id_re2_i & ex_we_i & (id_raddr2_i == ex_waddr_i) & (id_raddr2_i != 5'd0));

  // A start coinciding with a flush belongs to a squashed instruction.
  assign div_accept = (state_q == ST_IDLE) & ex_div_start_i & ~flush_req_i;

  // State register
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q   <= ST_IDLE;
      div_cnt_q <= 8'd0;
    end else begin
      state_q   <= state_d;
      div_cnt_q <= div_cnt_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d   = state_q;
    div_cnt_d = div_cnt_q;
    if (flush_req_i) begin
      state_d   = ST_IDLE;
      div_cnt_d = 8'd0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (ex_div_start_i) begin
            if (DIV_LOAD == 8'd0) begin
              state_d   = ST_DIV_DONE;
              div_cnt_d = 8'd0;
            end else begin
              state_d   = ST_DIV_BUSY;
              div_cnt_d = DIV_LOAD;
            end
          end
        end
        ST_DIV_BUSY: begin
          // Leave once the decrement reaches zero.
          if (div_cnt_q <= 8'd1) begin
            state_d   = ST_DIV_DONE;
            div_cnt_d = 8'd0;
          end else begin
            div_cnt_d = div_cnt_q - 8'd1;
          end
        end
        ST_DIV_DONE: begin
          state_d   = ST_IDLE;
          div_cnt_d = 8'd0;
        end
        default: begin
          state_d   = ST_IDLE;
          div_cnt_d = 8'd0;
        end
      endcase
    end
  end

  // Output logic
  always_comb begin
    div_busy_o = div_accept | (state_q == ST_DIV_BUSY);
    div_done_o = (state_q == ST_DIV_DONE);
    flush_o    = flush_req_i;
    new_pc_o   = flush_req_i ? flush_pc_i : 32'd0;
    if (flush_req_i) begin
      stall_o = 6'b000000;
    end else if (div_busy_o) begin
      stall_o = STALL_DIV;
    end else if (hazard) begin
      stall_o = STALL_HAZARD;
    end else begin
      stall_o = 6'b000000;
    end
  end

`ifdef PIPE_STALL_CNT_EN
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if ((stall_o != 6'd0) && (stall_cnt_q != {CNT_W{1'b1}})) begin
      stall_cnt_d = stall_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      stall_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_cnt_o = stall_cnt_q;
`else
  assign stall_cnt_o = '0;
`endif

endmodule
